output_requantizer: RTL

// - Downstream neighbour of the convolution engine: consumes its m_axis_output accumulator stream [BATCH, OH, OW, C_OUT].
// - Applies per-output-channel multiply, rounding right-shift and saturation to narrow results to OUT_WIDTH.
// - Regenerates and checks frame tlast, then forwards the result as an AXI-Stream master.

---
 rtl/requant_pkg.sv | 64 ++++++
 rtl/axis_skid_buffer.sv | 89 ++++++++
 rtl/output_requantizer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/requant_pkg.sv
// -----------------------------------------------------------------------------
// requant_pkg
// Shared widths, the per-channel coefficient type and the rounding/saturating
// narrowing function used by output_requantizer.
//
// Contents:
//   C_OUT_DEF/OH_DEF/OW_DEF  default frame geometry (channels, height, width)
//   IN_WIDTH..SHIFT_WIDTH    datapath widths
//   coef_t                   {mult, shift} per output channel
//   COEF_IDENTITY            mult=1, shift=0
//   sat_round()              rounding arithmetic right shift + saturation
// -----------------------------------------------------------------------------
package requant_pkg;

   localparam int C_OUT_DEF   = 64;
   localparam int OH_DEF      = 30;
   localparam int OW_DEF      = 30;

   localparam int IN_WIDTH    = 16;
   localparam int OUT_WIDTH   = 8;
   localparam int MULT_WIDTH  = 16;
   localparam int SHIFT_WIDTH = 5;

   localparam int PROD_WIDTH  = IN_WIDTH + MULT_WIDTH;
   // One guard bit so that adding the rounding constant to an extreme
   // product cannot wrap around.
   localparam int RND_WIDTH   = PROD_WIDTH + 1;

   localparam logic signed [RND_WIDTH-1:0] SAT_MAX = RND_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [RND_WIDTH-1:0] SAT_MIN = RND_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

   typedef struct packed {
      logic signed [MULT_WIDTH-1:0]  mult;
      logic        [SHIFT_WIDTH-1:0] shift;
   } coef_t;

   localparam coef_t COEF_IDENTITY = '{mult: MULT_WIDTH'(1), shift: '0};

   // Round half up (towards +inf on ties), arithmetic shift, then clamp to the
   // signed OUT_WIDTH range.
   function automatic logic signed [OUT_WIDTH-1:0] sat_round(
      input logic signed [PROD_WIDTH-1:0]  prod,
      input logic        [SHIFT_WIDTH-1:0] shift
   );
      logic signed [RND_WIDTH-1:0] wide;
      logic signed [RND_WIDTH-1:0] half;
      logic signed [RND_WIDTH-1:0] r;
      wide = RND_WIDTH'(prod);
      half = '0;
      if (shift != '0) begin
         half = RND_WIDTH'(1) << (shift - 1'b1);
         r    = (wide + half) >>> shift;
      end else begin
         r    = wide;
      end
      if (r > SAT_MAX) begin
         return SAT_MAX[OUT_WIDTH-1:0];
      end else if (r < SAT_MIN) begin
         return SAT_MIN[OUT_WIDTH-1:0];
      end
      return r[OUT_WIDTH-1:0];
   endfunction

endpackage : requant_pkg

// File: rtl/axis_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry elastic register for an AXI-Stream-like handshake. The output is
// fully registered and in_ready is a flop ("second entry empty"), so there is
// no combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    upstream beat
//   in_ready            registered: 1 when the spare entry is free
//   out_data/out_valid  registered downstream beat (stable while stalled)
//   out_ready           downstream ready
// -----------------------------------------------------------------------------
module axis_skid_buffer
   import requant_pkg::*;
#(
   parameter int WIDTH = OUT_WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             ready_q, ready_d;
   logic             in_fire;

   // NOTE: every variable written here gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      in_fire      = in_valid & ready_q;
      main_data_d  = main_data_q;
      main_valid_d = main_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;

      if (!main_valid_q || out_ready) begin
         // Output register is free (or draining this cycle): refill it,
         // oldest beat first.
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = in_fire;
            if (in_fire) begin
               main_data_d = in_data;
            end
         end
      end else if (in_fire) begin
         // Output is stalled: park the beat that was already promised a slot.
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end

      ready_d = ~skid_valid_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data_q  <= '0;
         main_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         main_data_q  <= main_data_d;
         main_valid_q <= main_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_data  = main_data_q;
   assign out_valid = main_valid_q;

endmodule : axis_skid_buffer

// File: rtl/output_requantizer.sv
// -----------------------------------------------------------------------------
// output_requantizer
// Consumes the convolution engine's accumulator stream (channel innermost),
// applies a per-channel multiply, rounding right shift and saturation down to
// OUT_WIDTH, regenerates frame tlast and flags producer tlast mismatches.
//
// Ports:
//   ap_clk, ap_rst            clock, asynchronous active-high reset
//   s_axis_acc_*              signed accumulator input stream (tdata/tvalid/
//                             tready/tlast)
//   cfg_wr_en/addr/mult/shift per-channel coefficient write port
//   m_axis_q_*                requantized output stream, tlast generated
//   err_tlast                 one-cycle pulse, one cycle after an input beat
//                             whose tlast disagrees with the generated one
//
// Pipeline: S1 {product, shift, last} -> S2 {rounded/saturated, last} -> skid.
// The whole pipeline advances together whenever the skid buffer can take a
// beat; that same registered signal is the input tready.
// -----------------------------------------------------------------------------
module output_requantizer
   import requant_pkg::*;
#(
   parameter int C_OUT = C_OUT_DEF,
   parameter int OH    = OH_DEF,
   parameter int OW    = OW_DEF
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   input  logic signed [IN_WIDTH-1:0]    s_axis_acc_tdata,
   input  logic                          s_axis_acc_tvalid,
   output logic                          s_axis_acc_tready,
   input  logic                          s_axis_acc_tlast,
   input  logic                          cfg_wr_en,
   input  logic [$clog2(C_OUT)-1:0]      cfg_addr,
   input  logic signed [MULT_WIDTH-1:0]  cfg_mult,
   input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
   output logic signed [OUT_WIDTH-1:0]   m_axis_q_tdata,
   output logic                          m_axis_q_tvalid,
   input  logic                          m_axis_q_tready,
   output logic                          m_axis_q_tlast,
   output logic                          err_tlast
);

   localparam int CH_W   = $clog2(C_OUT);
   localparam int PIXELS = OH * OW;
   localparam int PIX_W  = $clog2(PIXELS);

   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(C_OUT - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

   // ---------------------------------------------------------------- control
   logic advance;
   logic s_fire;
   logic last_gen;

   // ------------------------------------------------------ coefficient table
   coef_t coef_q [C_OUT];
   coef_t coef_d [C_OUT];
   coef_t coef_sel;

   always_comb begin
      coef_d = coef_q;
      if (cfg_wr_en && (int'(cfg_addr) < C_OUT)) begin
         coef_d[cfg_addr] = '{mult: cfg_mult, shift: cfg_shift};
      end
   end

   // NOTE: this small register file is deliberately reset (to identity) so a
   // reset always leaves a usable table; a large RAM would not be reset.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int i = 0; i < C_OUT; i++) begin
            coef_q[i] <= COEF_IDENTITY;
         end
      end else begin
         coef_q <= coef_d;
      end
   end

   // -------------------------------------------------- counters and checker
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic             err_tlast_q, err_tlast_d;

   always_comb begin
      s_fire      = s_axis_acc_tvalid & advance;
      last_gen    = (ch_q == CH_LAST) && (pix_q == PIX_LAST);
      ch_d        = ch_q;
      pix_d       = pix_q;
      err_tlast_d = 1'b0;

      if (s_fire) begin
         err_tlast_d = (s_axis_acc_tlast != last_gen);
         if (s_axis_acc_tlast) begin
            // Producer's frame boundary wins: resynchronise on it whether it
            // came early, on time or late.
            ch_d  = '0;
            pix_d = '0;
         end else if (ch_q == CH_LAST) begin
            ch_d  = '0;
            pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
         end else begin
            ch_d  = ch_q + 1'b1;
         end
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         ch_q        <= '0;
         pix_q       <= '0;
         err_tlast_q <= 1'b0;
      end else begin
         ch_q        <= ch_d;
         pix_q       <= pix_d;
         err_tlast_q <= err_tlast_d;
      end
   end

   // --------------------------------------------------------------- pipeline
   logic signed [PROD_WIDTH-1:0] prod;

   logic                         s1_valid_q, s1_valid_d;
   logic signed [PROD_WIDTH-1:0] s1_prod_q,  s1_prod_d;
   logic [SHIFT_WIDTH-1:0]       s1_shift_q, s1_shift_d;
   logic                         s1_last_q,  s1_last_d;

   logic                         s2_valid_q, s2_valid_d;
   logic signed [OUT_WIDTH-1:0]  s2_data_q,  s2_data_d;
   logic                         s2_last_q,  s2_last_d;

   always_comb begin
      // Table is read before this cycle's cfg write lands, so a same-cycle
      // write to the active channel takes effect from the next beat.
      coef_sel   = coef_q[ch_q];
      prod       = PROD_WIDTH'(s_axis_acc_tdata) * PROD_WIDTH'($signed(coef_sel.mult));

      s1_valid_d = s1_valid_q;
      s1_prod_d  = s1_prod_q;
      s1_shift_d = s1_shift_q;
      s1_last_d  = s1_last_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_last_d  = s2_last_q;

      if (advance) begin
         s1_valid_d = s_fire;
         s1_prod_d  = prod;
         s1_shift_d = coef_sel.shift;
         s1_last_d  = last_gen;
         s2_valid_d = s1_valid_q;
         s2_data_d  = sat_round(s1_prod_q, s1_shift_q);
         s2_last_d  = s1_last_q;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_shift_q <= '0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_prod_q  <= s1_prod_d;
         s1_shift_q <= s1_shift_d;
         s1_last_q  <= s1_last_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
      end
   end

   // ------------------------------------------------------------ output skid
   logic [OUT_WIDTH:0] skid_in;
   logic [OUT_WIDTH:0] skid_out;

   assign skid_in = {s2_last_q, s2_data_q};

   // S2 is offered to the skid every cycle; it is consumed exactly when the
   // pipeline advances, since both use the skid's registered ready.
   axis_skid_buffer #(
      .WIDTH (OUT_WIDTH + 1)
   ) u_skid (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .in_data   (skid_in),
      .in_valid  (s2_valid_q),
      .in_ready  (advance),
      .out_data  (skid_out),
      .out_valid (m_axis_q_tvalid),
      .out_ready (m_axis_q_tready)
   );

   assign m_axis_q_tdata    = skid_out[OUT_WIDTH-1:0];
   assign m_axis_q_tlast    = skid_out[OUT_WIDTH];
   assign s_axis_acc_tready = advance;
   assign err_tlast         = err_tlast_q;

endmodule : output_requantizer
